// File: rtl/lsu_mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// lsu_mem_ctrl_pkg
//   Shared definitions for the load/store sequencer: access-size encodings
//   (funct3[1:0]), the sequencer state type and small lane-arithmetic helpers
//   used both when a request is accepted and in the alignment datapath.
// ----------------------------------------------------------------------------
package lsu_mem_ctrl_pkg;

   localparam logic [1:0] LSU_SIZE_B = 2'b00;
   localparam logic [1:0] LSU_SIZE_H = 2'b01;
   localparam logic [1:0] LSU_SIZE_W = 2'b10;

   typedef enum logic [2:0] {
      LSU_IDLE   = 3'd0,
      LSU_ISSUE0 = 3'd1,
      LSU_WAIT0  = 3'd2,
      LSU_ISSUE1 = 3'd3,
      LSU_WAIT1  = 3'd4,
      LSU_RESP   = 3'd5
   } lsu_state_t;

   // Number of bytes touched by an access; the illegal encoding touches none.
   function automatic logic [3:0] lsu_nbytes(input logic [1:0] size);
      logic [3:0] n;
      case (size)
         LSU_SIZE_B: n = 4'd1;
         LSU_SIZE_H: n = 4'd2;
         LSU_SIZE_W: n = 4'd4;
         default:    n = 4'd0;
      endcase
      return n;
   endfunction

   // True when the byte range [off, off+nbytes) spills into the next word.
   function automatic logic lsu_crosses(input logic [1:0] size, input logic [1:0] off);
      return ({2'b00, off} + lsu_nbytes(size)) > 4'd4;
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// lsu_mem_ctrl_if
//   Bundles the CPU request/response handshake and the word-wide data-memory
//   port of the load/store sequencer.
//   master : the sequencer (accepts requests, drives the memory port)
//   slave  : its environment (CPU stage + data memory)
//   Signals:
//     req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata
//     rsp_valid/rsp_rdata/rsp_err
//     mem_req/mem_gnt/mem_we/mem_be/mem_addr/mem_wdata/mem_rvalid/mem_rdata
// ----------------------------------------------------------------------------
interface lsu_mem_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic        mem_req;
   logic        mem_gnt;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );

endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// ----------------------------------------------------------------------------
// lsu_mem_ctrl_align
//   Combinational lane alignment for the load/store sequencer.
//   Ports:
//     off      in  2   byte offset within the word (addr[1:0])
//     size     in  2   access size encoding
//     is_uns   in  1   zero-extend loads instead of sign-extending
//     wdata    in  32  right-aligned store data
//     rdata0   in  32  read word of the first access
//     rdata1   in  32  read word of the second access (0 if not split)
//     be8      out 8   byte enables across two consecutive words
//     wd64     out 64  store data shifted into its byte lanes
//     rdata    out 32  extracted and extended load data
// ----------------------------------------------------------------------------
module lsu_mem_ctrl_align
   import lsu_mem_ctrl_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        is_uns,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata0,
   input  logic [31:0] rdata1,
   output logic [7:0]  be8,
   output logic [63:0] wd64,
   output logic [31:0] rdata
);

   logic [3:0]  nbytes;
   logic [31:0] rsh;

   assign nbytes = lsu_nbytes(size);

   // A lane is enabled when it lies inside [off, off+nbytes).
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_be
         localparam logic [3:0] LANE = 4'(gi);
         assign be8[gi] = (LANE >= {2'b00, off}) && (LANE < ({2'b00, off} + nbytes));
      end
   endgenerate

   // Store data keeps all of rs2; only the enabled lanes reach memory.
   assign wd64 = {32'h0000_0000, wdata} << {off, 3'b000};

   // Both words form one 64-bit window so a split load extracts like an aligned one.
   assign rsh = 32'({rdata1, rdata0} >> {off, 3'b000});

   always_comb begin
      rdata = 32'h0000_0000;
      case (size)
         LSU_SIZE_B: rdata = is_uns ? {24'h00_0000, rsh[7:0]}  : {{24{rsh[7]}},  rsh[7:0]};
         LSU_SIZE_H: rdata = is_uns ? {16'h0000,    rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
         LSU_SIZE_W: rdata = rsh;
         default:    rdata = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_mem_ctrl
//   Load/store sequencer between the CPU memory stage and a word-wide data
//   memory. Takes one request at a time, issues one or two word accesses
//   (two when the access crosses a word boundary), then pulses rsp_valid.
//   Parameters:
//     SPLIT_EN  1: split word-crossing accesses; 0: answer them with rsp_err
//               without touching memory
//   Ports:
//     clk  in  clock, rising edge
//     rst  in  synchronous active-high reset
//     bus  lsu_mem_ctrl_if.master (CPU request/response + memory port)
// ----------------------------------------------------------------------------
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   lsu_mem_ctrl_if.master bus
);

   lsu_state_t  state_reg, state_next;

   logic        we_reg;
   logic [1:0]  size_reg;
   logic        uns_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic        err_reg, err_next;
   logic [31:0] rdata0_reg;
   logic [31:0] rdata1_reg;

   logic        accept;
   logic        cap0;
   logic        cap1;
   logic        split;

   logic [7:0]  be8;
   logic [63:0] wd64;
   logic [31:0] rdata_ext;
   logic [31:0] base_addr;

   lsu_mem_ctrl_align u_align (
      .off    (addr_reg[1:0]),
      .size   (size_reg),
      .is_uns (uns_reg),
      .wdata  (wdata_reg),
      .rdata0 (rdata0_reg),
      .rdata1 (rdata1_reg),
      .be8    (be8),
      .wd64   (wd64),
      .rdata  (rdata_ext)
   );

   assign base_addr = {addr_reg[31:2], 2'b00};
   assign split     = SPLIT_EN && (be8[7:4] != 4'b0000);

   // Next-state logic. The reject decision is made from the live request so
   // an erroring request can go straight to RESP.
   always_comb begin
      state_next = state_reg;
      err_next   = 1'b0;
      accept     = 1'b0;
      cap0       = 1'b0;
      cap1       = 1'b0;
      case (state_reg)
         LSU_IDLE: begin
            if (bus.req_valid) begin
               accept   = 1'b1;
               err_next = (bus.req_size == 2'b11) ||
                          (!SPLIT_EN && lsu_crosses(bus.req_size, bus.req_addr[1:0]));
               state_next = err_next ? LSU_RESP : LSU_ISSUE0;
            end
         end
         LSU_ISSUE0: if (bus.mem_gnt) state_next = LSU_WAIT0;
         LSU_WAIT0: begin
            if (bus.mem_rvalid) begin
               cap0       = 1'b1;
               state_next = split ? LSU_ISSUE1 : LSU_RESP;
            end
         end
         LSU_ISSUE1: if (bus.mem_gnt) state_next = LSU_WAIT1;
         LSU_WAIT1: begin
            if (bus.mem_rvalid) begin
               cap1       = 1'b1;
               state_next = LSU_RESP;
            end
         end
         LSU_RESP: state_next = LSU_IDLE;
         default:  state_next = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= LSU_IDLE;
         we_reg     <= 1'b0;
         size_reg   <= 2'b00;
         uns_reg    <= 1'b0;
         addr_reg   <= 32'h0000_0000;
         wdata_reg  <= 32'h0000_0000;
         err_reg    <= 1'b0;
         rdata0_reg <= 32'h0000_0000;
         rdata1_reg <= 32'h0000_0000;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            we_reg     <= bus.req_we;
            size_reg   <= bus.req_size;
            uns_reg    <= bus.req_unsigned;
            addr_reg   <= bus.req_addr;
            wdata_reg  <= bus.req_wdata;
            err_reg    <= err_next;
            // Clear the second word so unsplit loads see a clean upper window.
            rdata0_reg <= 32'h0000_0000;
            rdata1_reg <= 32'h0000_0000;
         end
         if (cap0) rdata0_reg <= bus.mem_rdata;
         if (cap1) rdata1_reg <= bus.mem_rdata;
      end
   end

   // Outputs are decoded from state so mem_* stay stable while waiting for gnt
   // and everything is zero outside the states that own it.
   always_comb begin
      bus.req_ready = (state_reg == LSU_IDLE);
      bus.rsp_valid = 1'b0;
      bus.rsp_err   = 1'b0;
      bus.rsp_rdata = 32'h0000_0000;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_be    = 4'b0000;
      bus.mem_addr  = 32'h0000_0000;
      bus.mem_wdata = 32'h0000_0000;
      case (state_reg)
         LSU_ISSUE0: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we_reg;
            bus.mem_be    = be8[3:0];
            bus.mem_addr  = base_addr;
            bus.mem_wdata = we_reg ? wd64[31:0] : 32'h0000_0000;
         end
         LSU_ISSUE1: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we_reg;
            bus.mem_be    = be8[7:4];
            bus.mem_addr  = base_addr + 32'd4;
            bus.mem_wdata = we_reg ? wd64[63:32] : 32'h0000_0000;
         end
         LSU_RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = err_reg;
            bus.rsp_rdata = (we_reg || err_reg) ? 32'h0000_0000 : rdata_ext;
         end
         default: ;
      endcase
   end

endmodule
